// File: rtl/gpio_pkg.sv
// Shared constants for the register-mapped GPIO controller: byte offsets of
// each register, register count and the widest supported pin vector.
package gpio_pkg;

    localparam int MAX_PINS      = 32;
    localparam int GPIO_NUM_REGS = 6;

    localparam logic [4:0] GPIO_OUT_OFS     = 5'h00;
    localparam logic [4:0] GPIO_DIR_OFS     = 5'h04;
    localparam logic [4:0] GPIO_IN_OFS      = 5'h08;
    localparam logic [4:0] GPIO_RISE_EN_OFS = 5'h0C;
    localparam logic [4:0] GPIO_FALL_EN_OFS = 5'h10;
    localparam logic [4:0] GPIO_IRQSTAT_OFS = 5'h14;

endpackage

// File: rtl/gpio_in_cond.sv
// Input conditioning for the GPIO pin vector: synchroniser, optional debounce
// (enabled by defining GPIO_DEBOUNCE_EN) and rise/fall edge outputs.
module gpio_in_cond #(
    parameter int NUM_PINS        = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] level,
    output logic [NUM_PINS-1:0] rise,
    output logic [NUM_PINS-1:0] fall
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("gpio_in_cond: SYNC_STAGES or DEBOUNCE_CYCLES out of range");
    end

    // Stage 0 is the flop closest to the pad; the top slice is sync_q.
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_reg;
    logic [NUM_PINS-1:0]                  sync_q;
    logic [NUM_PINS-1:0]                  prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    genvar gi;
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_db
        logic [CNT_W-1:0] cnt_reg;
        logic             lvl_reg;

        // Any cycle where sync_q agrees with the accepted level restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
                lvl_reg <= 1'b0;
            end else if (sync_q[gi] == lvl_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_reg <= '0;
                lvl_reg <= sync_q[gi];
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign level[gi] = lvl_reg;
    end
`else
    assign level = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;
    assign fall = ~level & prev_reg;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller on the valid/ready peripheral bus.
// Define GPIO_DEBOUNCE_EN to insert per-pin debounce counters on the inputs.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_PINS        = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reg_valid,
    output logic                reg_ready,
    input  logic [4:0]          reg_addr,
    input  logic [3:0]          reg_wstrb,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    if (NUM_PINS < 1 || NUM_PINS > MAX_PINS || GPIO_NUM_REGS > 8) begin : g_bad_param
        $error("gpio_ctrl: NUM_PINS out of range");
    end

    logic                ready_reg;
    logic [31:0]         rdata_reg;
    logic [4:0]          req_ofs_reg;
    logic [3:0]          req_wstrb_reg;
    logic [NUM_PINS-1:0] req_wdata_reg;
    logic [NUM_PINS-1:0] out_reg;
    logic [NUM_PINS-1:0] dir_reg;
    logic [NUM_PINS-1:0] rise_en_reg;
    logic [NUM_PINS-1:0] fall_en_reg;
    logic [NUM_PINS-1:0] stat_reg;
    logic [NUM_PINS-1:0] stat_next;
    logic                irq_reg;

    logic [NUM_PINS-1:0] in_level;
    logic [NUM_PINS-1:0] in_rise;
    logic [NUM_PINS-1:0] in_fall;
    logic [NUM_PINS-1:0] wmask;
    logic [NUM_PINS-1:0] irq_set;
    logic [NUM_PINS-1:0] irq_clr;
    logic [31:0]         rd_word;
    logic                accept;
    logic                commit;
    logic                wr_out;
    logic                wr_dir;
    logic                wr_rise;
    logic                wr_fall;
    logic                wr_stat;
    logic                unused_bits;

    gpio_in_cond #(
        .NUM_PINS        (NUM_PINS),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_in_cond (
        .clk     (clk),
        .reset   (reset),
        .gpio_in (gpio_in),
        .level   (in_level),
        .rise    (in_rise),
        .fall    (in_fall)
    );

    // The request is latched on acceptance and committed from the latch on the
    // reg_ready cycle, so the write does not depend on the master's hold time.
    assign accept = reg_valid & ~ready_reg;
    assign commit = ready_reg & (|req_wstrb_reg);

    genvar gi;
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_lane
        assign wmask[gi] = req_wstrb_reg[gi / 8];
    end

    assign wr_out  = commit && (req_ofs_reg == GPIO_OUT_OFS);
    assign wr_dir  = commit && (req_ofs_reg == GPIO_DIR_OFS);
    assign wr_rise = commit && (req_ofs_reg == GPIO_RISE_EN_OFS);
    assign wr_fall = commit && (req_ofs_reg == GPIO_FALL_EN_OFS);
    assign wr_stat = commit && (req_ofs_reg == GPIO_IRQSTAT_OFS);

    // Set is OR-ed in after the clear so a coincident edge keeps its bit.
    assign irq_set   = (in_rise & rise_en_reg) | (in_fall & fall_en_reg);
    assign irq_clr   = wr_stat ? (req_wdata_reg & wmask) : '0;
    assign stat_next = (stat_reg & ~irq_clr) | irq_set;

    always_comb begin
        rd_word = '0;
        case ({reg_addr[4:2], 2'b00})
            GPIO_OUT_OFS:     rd_word[NUM_PINS-1:0] = out_reg;
            GPIO_DIR_OFS:     rd_word[NUM_PINS-1:0] = dir_reg;
            GPIO_IN_OFS:      rd_word[NUM_PINS-1:0] = in_level;
            GPIO_RISE_EN_OFS: rd_word[NUM_PINS-1:0] = rise_en_reg;
            GPIO_FALL_EN_OFS: rd_word[NUM_PINS-1:0] = fall_en_reg;
            GPIO_IRQSTAT_OFS: rd_word[NUM_PINS-1:0] = stat_reg;
            default:          rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg     <= 1'b0;
            rdata_reg     <= '0;
            req_ofs_reg   <= '0;
            req_wstrb_reg <= '0;
            req_wdata_reg <= '0;
            out_reg       <= '0;
            dir_reg       <= '0;
            rise_en_reg   <= '0;
            fall_en_reg   <= '0;
            stat_reg      <= '0;
            irq_reg       <= 1'b0;
        end else begin
            ready_reg <= accept;
            rdata_reg <= (accept && reg_wstrb == 4'b0000) ? rd_word : 32'h0;
            if (accept) begin
                req_ofs_reg   <= {reg_addr[4:2], 2'b00};
                req_wstrb_reg <= reg_wstrb;
                req_wdata_reg <= reg_wdata[NUM_PINS-1:0];
            end
            if (wr_out) begin
                out_reg <= (out_reg & ~wmask) | (req_wdata_reg & wmask);
            end
            if (wr_dir) begin
                dir_reg <= (dir_reg & ~wmask) | (req_wdata_reg & wmask);
            end
            if (wr_rise) begin
                rise_en_reg <= (rise_en_reg & ~wmask) | (req_wdata_reg & wmask);
            end
            if (wr_fall) begin
                fall_en_reg <= (fall_en_reg & ~wmask) | (req_wdata_reg & wmask);
            end
            stat_reg <= stat_next;
            irq_reg  <= |stat_reg;
        end
    end

    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    assign reg_ready = ready_reg;
    assign reg_rdata = rdata_reg;
    assign gpio_out  = out_reg;
    assign gpio_oe   = dir_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: randomized bus and pin stimulus checked
// against a register-level reference model.
`timescale 1ns/1ps
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int NP = 12;
    localparam int SS = 3;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int SETTLE = SS + DB + 6;
    localparam logic [31:0] PMASK = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_valid;
    logic          reg_ready;
    logic [4:0]    reg_addr;
    logic [3:0]    reg_wstrb;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic [NP-1:0] gpio_in;
    logic [NP-1:0] gpio_out;
    logic [NP-1:0] gpio_oe;
    logic          irq;

    gpio_ctrl #(
        .NUM_PINS        (NP),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_valid (reg_valid),
        .reg_ready (reg_ready),
        .reg_addr  (reg_addr),
        .reg_wstrb (reg_wstrb),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat;
    logic prev_ready = 1'b0;

    // Reference model: architectural register contents and current pin levels.
    logic [31:0] m_out, m_dir, m_rise, m_fall, m_stat, m_pins;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, expv);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case ({a[4:2], 2'b00})
            GPIO_OUT_OFS:     return m_out;
            GPIO_DIR_OFS:     return m_dir;
            GPIO_IN_OFS:      return m_pins;
            GPIO_RISE_EN_OFS: return m_rise;
            GPIO_FALL_EN_OFS: return m_fall;
            GPIO_IRQSTAT_OFS: return m_stat;
            default:          return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] bm;
        bm = lanes(s) & PMASK;
        case ({a[4:2], 2'b00})
            GPIO_OUT_OFS:     m_out  = (m_out  & ~bm) | (d & bm);
            GPIO_DIR_OFS:     m_dir  = (m_dir  & ~bm) | (d & bm);
            GPIO_RISE_EN_OFS: m_rise = (m_rise & ~bm) | (d & bm);
            GPIO_FALL_EN_OFS: m_fall = (m_fall & ~bm) | (d & bm);
            GPIO_IRQSTAT_OFS: m_stat = m_stat & ~(d & bm);
            default: ;
        endcase
    endtask

    // A settled pin change is an edge on every bit that differs.
    task automatic model_pins(input logic [31:0] v);
        logic [31:0] nv;
        nv = v & PMASK;
        m_stat = m_stat | ((nv & ~m_pins & m_rise) | (~nv & m_pins & m_fall));
        m_pins = nv;
    endtask

    task automatic bus(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_t e;
        int   waited;
        e.is_read = (s == 4'b0000);
        e.addr    = a;
        e.data    = model_read(a);
        exp_q.push_back(e);
        if (s != 4'b0000) model_write(a, s, d);
        @(negedge clk);
        reg_addr  = a;
        reg_wstrb = s;
        reg_wdata = d;
        reg_valid = 1'b1;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!reg_ready && waited < 20);
        reg_valid = 1'b0;
        chk("bus_ready", 32'(reg_ready), 32'h1);
        if (!reg_ready) void'(exp_q.pop_back());
    endtask

    task automatic rd(input logic [4:0] a);
        bus(a, 4'b0000, 32'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        bus(a, s, d);
        @(negedge clk);
        chk("gpio_out", 32'(gpio_out), m_out);
        chk("gpio_oe", 32'(gpio_oe), m_dir);
        @(negedge clk);
        chk("irq_after_wr", 32'(irq), 32'(m_stat != 0));
    endtask

    task automatic pins_set(input logic [31:0] v);
        model_pins(v);
        @(negedge clk);
        gpio_in = v[NP-1:0];
        repeat (SETTLE) @(negedge clk);
        chk("irq_after_pins", 32'(irq), 32'(m_stat != 0));
    endtask

    // Monitor: pops one expectation per reg_ready pulse.
    always @(negedge clk) begin
        if (reg_ready) begin
            chk("ready_pulse", 32'(prev_ready), 32'h0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'(exp_q.size()), 32'h1);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) chk($sformatf("rd_%02h", mon_e.addr), reg_rdata, mon_e.data);
            end
        end else if (prev_ready) begin
            chk("rdata_idle", reg_rdata, 32'h0);
        end
        prev_ready = reg_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        reg_valid = 1'b0;
        reg_addr  = '0;
        reg_wstrb = '0;
        reg_wdata = '0;
        gpio_in   = '0;
        {m_out, m_dir, m_rise, m_fall, m_stat, m_pins} = '0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) rd(5'(i * 4));

        wr(GPIO_OUT_OFS, 4'b0101, 32'hA5A5_1234);
        rd(GPIO_OUT_OFS);
        wr(GPIO_DIR_OFS, 4'b1111, 32'hFFFF_FFFF);
        rd(GPIO_DIR_OFS);
        wr(GPIO_IN_OFS, 4'b1111, 32'hFFFF_FFFF);
        rd(GPIO_IN_OFS);

        // Pin edge to irq latency
        wr(GPIO_RISE_EN_OFS, 4'b1111, 32'h1);
        model_pins(32'h1);
        @(negedge clk);
        gpio_in = NP'(1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (irq && lat == 0) lat = c;
        end
        chk("irq_latency", 32'(lat), 32'(SS + 2 + DB));
        rd(GPIO_IRQSTAT_OFS);
        pins_set(32'h0);
        rd(GPIO_IRQSTAT_OFS);

        // W1C: irq still high one cycle after reg_ready, low the next
        bus(GPIO_IRQSTAT_OFS, 4'b1111, 32'h1);
        @(negedge clk);
        chk("irq_w1c_hold", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_w1c_drop", 32'(irq), 32'h0);

        // W1C landing on the same edge as a new fall-edge set
        wr(GPIO_FALL_EN_OFS, 4'b1111, 32'h2);
        pins_set(32'h2);
        pins_set(32'h0);
        pins_set(32'h2);
        @(negedge clk);
        gpio_in = '0;
        repeat (SS - 2 + DB) @(negedge clk);
        bus(GPIO_IRQSTAT_OFS, 4'b1111, 32'h2);
        model_pins(32'h0);
        repeat (3) @(negedge clk);
        chk("coincide_irq", 32'(irq), 32'h1);
        rd(GPIO_IRQSTAT_OFS);
        wr(GPIO_IRQSTAT_OFS, 4'b1111, 32'h2);
        rd(GPIO_IRQSTAT_OFS);

        // Enabling a rise on an already-high pin must not set status
        pins_set(32'h4);
        wr(GPIO_RISE_EN_OFS, 4'b1111, 32'h5);
        repeat (SETTLE) @(negedge clk);
        rd(GPIO_IRQSTAT_OFS);
        pins_set(32'h0);

        // Reset in the middle of a request: no ready pulse, state cleared
        @(negedge clk);
        reg_addr  = GPIO_OUT_OFS;
        reg_wstrb = 4'b1111;
        reg_wdata = 32'hFFFF_FFFF;
        reg_valid = 1'b1;
        reset     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_ready", 32'(reg_ready), 32'h0);
        end
        reg_valid = 1'b0;
        reset     = 1'b0;
        {m_out, m_dir, m_rise, m_fall, m_stat} = '0;
        @(negedge clk);
        chk("abort_gpio_out", 32'(gpio_out), 32'h0);
        rd(GPIO_OUT_OFS);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: wr(5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
                      4'($urandom_range(1, 15)), $urandom);
                1: rd(5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)));
                2: pins_set($urandom);
                default: wr(($urandom_range(0, 1) == 0) ? GPIO_RISE_EN_OFS : GPIO_FALL_EN_OFS,
                            4'b1111, $urandom);
            endcase
        end
        for (int i = 0; i < 8; i++) rd(5'(i * 4));

`ifdef GPIO_DEBOUNCE_EN
        pins_set(32'h0);
        wr(GPIO_FALL_EN_OFS, 4'b1111, 32'h0);
        wr(GPIO_RISE_EN_OFS, 4'b1111, 32'h8);
        wr(GPIO_IRQSTAT_OFS, 4'b1111, 32'hFFFF_FFFF);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (10) @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("glitch_irq", 32'(irq), 32'h0);
        rd(GPIO_IN_OFS);
        rd(GPIO_IRQSTAT_OFS);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 20) gpio_in[3] = 1'b0;
            if (irq && lat == 0) lat = c;
        end
        chk("db_irq_latency", 32'(lat), 32'(SS + 2 + DB));
        m_stat = m_stat | 32'h8;
        repeat (SETTLE) @(negedge clk);
        rd(GPIO_IRQSTAT_OFS);
        rd(GPIO_IN_OFS);
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised, register-mapped GPIO controller; successor to the combinational byte-lane GPIO.
- Adds registered outputs, per-pin direction, input synchronisation, rise/fall edge detection and a level interrupt.
- Sits on the SoC's simple valid/ready memory-mapped peripheral bus beside the CPU; pins go to top-level pads or to internal logic-analyser signals.

Parameters:
- NUM_PINS, 32, implemented pins (1..32); register bits at or above NUM_PINS read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages on gpio_in (2..4).
- DEBOUNCE_CYCLES, 16, stable-cycle count per pin; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reg_valid  in  1  bus request; held high until reg_ready.
- reg_ready  out  1  one-cycle completion pulse.
- reg_addr  in  5  byte address; bits [1:0] ignored.
- reg_wstrb  in  4  byte write enables; 0 = read.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data; valid while reg_ready=1, else 0.
- gpio_in  in  NUM_PINS  asynchronous pin inputs.
- gpio_out  out  NUM_PINS  output data register.
- gpio_oe  out  NUM_PINS  output enable (1 = drive).
- irq  out  1  level interrupt, active high.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: gpio_out=0, gpio_oe=0, reg_ready=0, reg_rdata=0, irq=0. All registers and synchroniser flops clear to 0.
- Register map (word offsets):
  - 0x00 OUT, RW.
  - 0x04 DIR, RW; drives gpio_oe.
  - 0x08 IN, RO; synchronised value.
  - 0x0C RISE_EN, RW.
  - 0x10 FALL_EN, RW.
  - 0x14 IRQ_STAT, read / write-1-to-clear.
  - Unmapped offsets read 0; writes to them are ignored.
- Handshake:
  - reg_ready rises the cycle after reg_valid is seen with reg_ready low, and stays high exactly one cycle.
  - A write commits on the reg_ready cycle, honouring each reg_wstrb byte lane independently.
  - If reg_valid is held high continuously, one transaction completes every 2 cycles.
  - Writes to IN are ignored.
- Input path: gpio_in passes through SYNC_STAGES flops, giving sync_q; IN reflects sync_q.
- Edge detection: prev_q registers sync_q each cycle.
  - rise = sync_q & ~prev_q; fall = ~sync_q & prev_q.
  - IRQ_STAT[i] sets on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, and the bit stays 1.
- Enables are not retroactive: enabling RISE_EN on a pin that is already high does not set its status bit.
- irq is registered: irq = |IRQ_STAT, one cycle after IRQ_STAT changes.
- Latency, pin edge to irq: SYNC_STAGES+2 cycles (+DEBOUNCE_CYCLES when debounce is on).
- Output: gpio_out/gpio_oe update the cycle after the committing reg_ready.
- Reset during a transaction: the transaction is aborted, no write commits, and reg_ready stays 0. The master reissues the request.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Per-pin counter of width clog2(DEBOUNCE_CYCLES+1) sits between sync_q and the IN/edge logic.
  - The debounced value updates only after sync_q differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch shorter than that restarts the count and is never visible.
- Undefined: sync_q feeds IN and edge detection directly; no counters are synthesised.

Decomposition:
- Shared package gpio_pkg holds register offset localparams (GPIO_OUT_OFS … GPIO_IRQSTAT_OFS), the register count, and the MAX_PINS=32 constant.
- One natural sub-module: gpio_in_cond, one instance per pin vector. It covers the synchroniser, the optional debounce and the rise/fall outputs, so the register/bus logic in gpio_ctrl stays separate.

Test Plan:
- Reset then read all offsets -> every read returns 0x00000000; gpio_oe=0; irq=0.
- Write OUT=0xA5A5_1234 with wstrb=4'b0101, then read -> 0x00A5_0034; gpio_out matches the cycle after reg_ready.
- NUM_PINS=8, write DIR=0xFFFF_FFFF -> DIR reads 0x0000_00FF; gpio_oe=8'hFF.
- RISE_EN=0x1, drive gpio_in[0] 0->1 -> IRQ_STAT=0x1 and irq=1 exactly SYNC_STAGES+2 cycles later. A falling edge does not set the bit. Writing IRQ_STAT=0x1 drops irq 2 cycles after the write's reg_ready.
- FALL_EN=0x2, W1C of bit1 coincides with a fall edge on pin1 -> IRQ_STAT[1] stays 1 and irq stays high.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A 10-cycle pulse on gpio_in[3] -> IN[3] never changes and no IRQ.
  - A 20-cycle pulse -> IN[3]=1 after SYNC_STAGES+16 cycles.
